// File: rtl/exp_log.sv
`default_nettype none
// ============================================================================
//  Module   : exp_log
//  Purpose  : Integer logarithm. Given base X and value P, computes
//             A = floor(log_X(P)) by repeatedly multiplying an accumulator
//             by X. It does one multiply-and-compare per clock and needs
//             no divider. It also reports whether P is an exact power of X.
//             Uses the same load/start/done handshake as the exponent core.
//  Ports    : i_clk    - clock, rising edge
//             i_rst    - asynchronous active-high reset
//             i_load   - latch i_X / i_P into the operand registers
//             i_start  - begin computation on the latched operands
//             i_X      - base (BASE_W bits)
//             i_P      - value whose logarithm is taken (DATA_W bits)
//             o_done   - result valid; level, held until next load/start
//             o_A      - floor(log_X(P)) (EXP_W bits)
//             o_exact  - 1 when X^o_A == P
//             o_err    - 1 when operands are invalid (X<2 or P==0)
//  Revision : 1.0 - initial release
// ============================================================================
module exp_log #(
  parameter int DATA_W = 15,
  parameter int BASE_W = 4,
  parameter int EXP_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_start,
  input  logic [BASE_W-1:0] i_X,
  input  logic [DATA_W-1:0] i_P,
  output logic              o_done,
  output logic [EXP_W-1:0]  o_A,
  output logic              o_exact,
  output logic              o_err
);

  localparam int c_acc_w = DATA_W + BASE_W;
  localparam logic [c_acc_w-1:0] c_acc_one = c_acc_w'(1);
  localparam logic [EXP_W-1:0]   c_cnt_one = EXP_W'(1);
  localparam logic [BASE_W-1:0]  c_base_min = BASE_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BASE_W-1:0]   r_x, w_x_nxt;
  logic [DATA_W-1:0]   r_p, w_p_nxt;
  logic [c_acc_w-1:0]  r_acc, w_acc_nxt;
  logic [EXP_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_done, w_done_nxt;
  logic [EXP_W-1:0]    r_a, w_a_nxt;
  logic                r_exact, w_exact_nxt;
  logic                r_err, w_err_nxt;

  logic [c_acc_w-1:0]  w_p_ext;
  logic [c_acc_w-1:0]  w_prod;

  assign w_p_ext = {{BASE_W{1'b0}}, r_p};
  // The multiply only happens while acc < P < 2^DATA_W and X < 2^BASE_W,
  // so the product always fits the accumulator and truncation is lossless.
  assign w_prod  = r_acc * c_acc_w'(r_x);

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_exact <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_p     <= w_p_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_a     <= w_a_nxt;
      r_exact <= w_exact_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_p_nxt     = r_p;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_a_nxt     = r_a;
    w_exact_nxt = r_exact;
    w_err_nxt   = r_err;

    case (r_state)
      IDLE: begin
        if (i_load) begin
          w_x_nxt = i_X;
          w_p_nxt = i_P;
        end else if (i_start) begin
          w_acc_nxt   = c_acc_one;
          w_cnt_nxt   = '0;
          w_a_nxt     = '0;
          w_exact_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = CALC;
        end
      end

      CALC: begin
        if ((r_x < c_base_min) || (r_p == '0)) begin
          w_err_nxt   = 1'b1;
          w_a_nxt     = '0;
          w_exact_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_acc == w_p_ext) begin
          w_a_nxt     = r_cnt;
          w_exact_nxt = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_acc > w_p_ext) begin
          // Overshoot: cnt >= 1 here because acc starts at 1 <= P.
          w_a_nxt     = r_cnt - c_cnt_one;
          w_exact_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_acc_nxt = w_prod;
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      DONE: begin
        if (i_load) begin
          w_x_nxt     = i_X;
          w_p_nxt     = i_P;
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (i_start) begin
          w_acc_nxt   = c_acc_one;
          w_cnt_nxt   = '0;
          w_a_nxt     = '0;
          w_exact_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = CALC;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_done  = r_done;
  assign o_A     = r_a;
  assign o_exact = r_exact;
  assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_exp_log.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exp_log
//  Purpose  : Directed self-checking bench for exp_log. Each step loads
//             operands, starts the core and compares latency and results
//             against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exp_log;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_load;
  logic        i_start;
  logic [3:0]  i_X;
  logic [14:0] i_P;
  logic        o_done;
  logic [3:0]  o_A;
  logic        o_exact;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int lat;

  exp_log #(
    .DATA_W (15),
    .BASE_W (4),
    .EXP_W  (4)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (i_load),
    .i_start (i_start),
    .i_X     (i_X),
    .i_P     (i_P),
    .o_done  (o_done),
    .o_A     (o_A),
    .o_exact (o_exact),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] x, input logic [14:0] p);
    @(negedge i_clk);
    i_load = 1'b1;
    i_X    = x;
    i_P    = p;
    @(negedge i_clk);
    i_load = 1'b0;
  endtask

  // Pulses start, then counts edges after the start edge until o_done.
  // pulse_at > 0 re-asserts i_start so it is sampled at that edge (mid-CALC).
  task automatic start_wait(input int pulse_at, output int latency);
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("done_low_after_start", {31'd0, o_done}, 32'd0);
    latency = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == pulse_at) i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_done === 1'b1) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [3:0] x, input logic [14:0] p, input int exp_a,
                     input int exp_exact, input int exp_err, input int exp_lat,
                     input int pulse_at);
    int l;
    do_load(x, p);
    start_wait(pulse_at, l);
    check($sformatf("X%0d_P%0d_latency", x, p), l, exp_lat);
    check($sformatf("X%0d_P%0d_A", x, p), {28'd0, o_A}, exp_a);
    check($sformatf("X%0d_P%0d_exact", x, p), {31'd0, o_exact}, exp_exact);
    check($sformatf("X%0d_P%0d_err", x, p), {31'd0, o_err}, exp_err);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_load  = 1'b0;
    i_start = 1'b0;
    i_X     = '0;
    i_P     = '0;
    repeat (2) @(negedge i_clk);
    check("reset_done",  {31'd0, o_done},  32'd0);
    check("reset_A",     {28'd0, o_A},     32'd0);
    check("reset_exact", {31'd0, o_exact}, 32'd0);
    check("reset_err",   {31'd0, o_err},   32'd0);
    i_rst = 1'b0;

    // Main function: exact, inexact, maximum result, P==1
    run(4'd2,  15'd8,     3, 1, 0, 4,  0);
    // Restart on the same operands: done drops, identical result returns
    start_wait(0, lat);
    check("restart_latency", lat, 4);
    check("restart_A",       {28'd0, o_A},     32'd3);
    check("restart_exact",   {31'd0, o_exact}, 32'd1);

    run(4'd3,  15'd100,   4, 0, 0, 6,  0);
    run(4'd2,  15'd32767, 14, 0, 0, 16, 0);
    run(4'd15, 15'd1,     0, 1, 0, 1,  0);
    run(4'd10, 15'd9999,  3, 0, 0, 5,  0);

    // Invalid operands
    run(4'd1, 15'd5, 0, 0, 1, 1, 0);
    run(4'd0, 15'd5, 0, 0, 1, 1, 0);
    run(4'd4, 15'd0, 0, 0, 1, 1, 0);

    // Load and start together in DONE: operands taken, no computation
    @(negedge i_clk);
    i_load  = 1'b1;
    i_start = 1'b1;
    i_X     = 4'd3;
    i_P     = 15'd9;
    @(negedge i_clk);
    i_load  = 1'b0;
    i_start = 1'b0;
    check("load_start_done_cleared", {31'd0, o_done}, 32'd0);
    repeat (6) @(negedge i_clk);
    check("load_start_no_compute", {31'd0, o_done}, 32'd0);
    start_wait(0, lat);
    check("new_operands_latency", lat, 3);
    check("new_operands_A",       {28'd0, o_A},     32'd2);
    check("new_operands_exact",   {31'd0, o_exact}, 32'd1);
    check("new_operands_err",     {31'd0, o_err},   32'd0);

    // Start during CALC is ignored: latency unchanged
    run(4'd2, 15'd1024, 10, 1, 0, 11, 3);

    // Asynchronous reset from DONE clears outputs without a clock edge
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("async_rst_done",  {31'd0, o_done},  32'd0);
    check("async_rst_A",     {28'd0, o_A},     32'd0);
    check("async_rst_exact", {31'd0, o_exact}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset in the middle of CALC
    do_load(4'd2, 15'd1024);
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("mid_rst_done",  {31'd0, o_done},  32'd0);
    check("mid_rst_A",     {28'd0, o_A},     32'd0);
    check("mid_rst_exact", {31'd0, o_exact}, 32'd0);
    check("mid_rst_err",   {31'd0, o_err},   32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    check("mid_rst_idle", {31'd0, o_done}, 32'd0);
    // Operands were cleared by reset, so a bare start reports an error
    start_wait(0, lat);
    check("post_rst_latency", lat, 1);
    check("post_rst_err",     {31'd0, o_err},   32'd1);
    check("post_rst_A",       {28'd0, o_A},     32'd0);
    check("post_rst_exact",   {31'd0, o_exact}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
